// File: rtl/ipv4_dst_extract_if.sv
// ipv4_dst_extract_if
//   Bundles the receive byte stream, the TCAM lookup port, the routed-result
//   handshake and the statistics counters of ipv4_dst_extract.
//   Ports (signal groups):
//     rx_*            byte stream from the Ethernet receive path
//     lookup_*        destination address and strobe toward the TCAM
//     tcam_*          next-hop / interface result from the TCAM
//     route_*         valid/ready result toward downstream
//     stat_*          saturating statistics counters (CNT_W bits)
//   Modports: slave = the extractor, master = its environment.
interface ipv4_dst_extract_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_sof;
    logic             rx_eof;
    logic [31:0]      lookup_addr;
    logic             lookup_req;
    logic [31:0]      tcam_addr_out;
    logic [3:0]       tcam_if_idx;
    logic             route_valid;
    logic             route_ready;
    logic [31:0]      route_dst;
    logic [31:0]      route_next_hop;
    logic [3:0]       route_if_idx;
    logic [CNT_W-1:0] stat_ipv4;
    logic [CNT_W-1:0] stat_drop;
    logic [CNT_W-1:0] stat_ovf;

    modport slave (
        input  rx_data, rx_valid, rx_sof, rx_eof,
        input  tcam_addr_out, tcam_if_idx, route_ready,
        output lookup_addr, lookup_req,
        output route_valid, route_dst, route_next_hop, route_if_idx,
        output stat_ipv4, stat_drop, stat_ovf
    );

    modport master (
        output rx_data, rx_valid, rx_sof, rx_eof,
        output tcam_addr_out, tcam_if_idx, route_ready,
        input  lookup_addr, lookup_req,
        input  route_valid, route_dst, route_next_hop, route_if_idx,
        input  stat_ipv4, stat_drop, stat_ovf
    );
endinterface

// File: rtl/ipv4_dst_extract.sv
// ipv4_dst_extract
//   Parses an Ethernet byte stream, qualifies IPv4 frames, extracts the
//   destination address, strobes a TCAM lookup, captures the TCAM result
//   after LOOKUP_LAT cycles and offers it downstream on valid/ready.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   ipv4_dst_extract_if.slave (rx stream, TCAM port, route result,
//           statistics counters)
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | between frames, waiting for rx_sof
//   PARSE | checking header bytes at offset bc, collecting dst addr
//   SKIP  | frame decided (lookup issued or rejected), wait for rx_eof
module ipv4_dst_extract #(
    parameter int LOOKUP_LAT = 1,
    parameter int CNT_W      = 16
) (
    input logic                 clk,
    input logic                 rst,
    ipv4_dst_extract_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, PARSE, SKIP} state_t;

    localparam logic [3:0]       LAT4    = 4'(LOOKUP_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state, state_nxt;
    logic [5:0]        bc, bc_nxt;
    logic [23:0]       dst_sr, dst_sr_nxt;     // bytes 30..32; byte 33 joins on issue
    logic              bad, drop_inc, ipv4_inc, issue;

    logic [31:0]       lookup_addr;
    logic              lookup_req;
    logic [3:0]        lat_cnt;
    logic              sample;
    logic              route_valid;
    logic [31:0]       route_dst, route_next_hop;
    logic [3:0]        route_if_idx;
    logic [CNT_W-1:0]  stat_ipv4, stat_drop, stat_ovf;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        bc_nxt     = bc;
        dst_sr_nxt = dst_sr;
        bad        = 1'b0;
        drop_inc   = 1'b0;
        ipv4_inc   = 1'b0;
        issue      = 1'b0;
        if (bus.rx_valid) begin
            if (bus.rx_sof) begin
                // A new frame while still parsing means the previous one was cut short.
                drop_inc  = (state == PARSE);
                bc_nxt    = 6'd1;
                state_nxt = PARSE;
            end else begin
                case (state)
                    PARSE: begin
                        if (bc != 6'd63) bc_nxt = bc + 6'd1;
                        bad = (bc == 6'd12 && bus.rx_data != 8'h08) ||
                              (bc == 6'd13 && bus.rx_data != 8'h00) ||
                              (bc == 6'd14 && bus.rx_data[7:4] != 4'h4);
                        if (bc >= 6'd30 && bc <= 6'd32)
                            dst_sr_nxt = {dst_sr[15:0], bus.rx_data};
                        if (bad) begin
                            drop_inc  = 1'b1;
                            state_nxt = bus.rx_eof ? IDLE : SKIP;
                        end else if (bc == 6'd33) begin
                            ipv4_inc  = 1'b1;
                            issue     = 1'b1;
                            state_nxt = bus.rx_eof ? IDLE : SKIP;
                        end else if (bus.rx_eof) begin
                            drop_inc  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                    SKIP: begin
                        if (bus.rx_eof) state_nxt = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // The TCAM result is valid on the terminal count of the latency timer.
    assign sample = (lat_cnt == 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            bc             <= '0;
            dst_sr         <= '0;
            lookup_addr    <= '0;
            lookup_req     <= 1'b0;
            lat_cnt        <= '0;
            route_valid    <= 1'b0;
            route_dst      <= '0;
            route_next_hop <= '0;
            route_if_idx   <= '0;
            stat_ipv4      <= '0;
            stat_drop      <= '0;
            stat_ovf       <= '0;
        end else begin
            bc         <= bc_nxt;
            dst_sr     <= dst_sr_nxt;
            lookup_req <= issue;
            if (issue) lookup_addr <= {dst_sr, bus.rx_data};

            if (lookup_req)          lat_cnt <= LAT4;
            else if (lat_cnt != '0)  lat_cnt <= lat_cnt - 4'd1;

            if (sample) begin
                if (!route_valid || bus.route_ready) begin
                    route_valid    <= 1'b1;
                    route_dst      <= lookup_addr;
                    route_next_hop <= bus.tcam_addr_out;
                    route_if_idx   <= bus.tcam_if_idx;
                end else if (stat_ovf != CNT_MAX) begin
                    stat_ovf <= stat_ovf + CNT_ONE;
                end
            end else if (route_valid && bus.route_ready) begin
                route_valid <= 1'b0;
            end

            if (ipv4_inc && stat_ipv4 != CNT_MAX) stat_ipv4 <= stat_ipv4 + CNT_ONE;
            if (drop_inc && stat_drop != CNT_MAX) stat_drop <= stat_drop + CNT_ONE;
        end
    end

    assign bus.lookup_addr    = lookup_addr;
    assign bus.lookup_req     = lookup_req;
    assign bus.route_valid    = route_valid;
    assign bus.route_dst      = route_dst;
    assign bus.route_next_hop = route_next_hop;
    assign bus.route_if_idx   = route_if_idx;
    assign bus.stat_ipv4      = stat_ipv4;
    assign bus.stat_drop      = stat_drop;
    assign bus.stat_ovf       = stat_ovf;
endmodule

// File: tb/tb_ipv4_dst_extract.sv
module tb_ipv4_dst_extract;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst4 = 1'b1;

    always #5 clk = ~clk;

    ipv4_dst_extract_if #(.CNT_W(16)) bus ();
    ipv4_dst_extract_if #(.CNT_W(4))  bus4 ();

    ipv4_dst_extract #(.LOOKUP_LAT(1), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ipv4_dst_extract #(.LOOKUP_LAT(1), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    // Narrow-counter instance sees the same byte stream.
    assign bus4.rx_data       = bus.rx_data;
    assign bus4.rx_valid      = bus.rx_valid;
    assign bus4.rx_sof        = bus.rx_sof;
    assign bus4.rx_eof        = bus.rx_eof;
    assign bus4.tcam_addr_out = 32'h0;
    assign bus4.tcam_if_idx   = 4'h0;
    assign bus4.route_ready   = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int req_cnt = 0;
    logic [31:0] req_addr = '0;
    logic [7:0] frm [0:63];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic build(input logic [31:0] dst, input logic [15:0] etype, input logic [7:0] ver_ihl);
        for (int i = 0; i < 64; i++) frm[i] = 8'(i * 7 + 3);
        frm[12] = etype[15:8];
        frm[13] = etype[7:0];
        frm[14] = ver_ihl;
        frm[30] = dst[31:24];
        frm[31] = dst[23:16];
        frm[32] = dst[15:8];
        frm[33] = dst[7:0];
    endtask

    // Leaves the last byte driven; caller follows with idle() or another frame.
    task automatic send_frame(input int len, input bit with_eof);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b1;
            bus.rx_data  = frm[i];
            bus.rx_sof   = (i == 0);
            bus.rx_eof   = with_eof && (i == len - 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            bus.rx_sof   = 1'b0;
            bus.rx_eof   = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (bus.lookup_req) begin
            req_cnt++;
            req_addr = bus.lookup_addr;
        end
    end

    initial begin
        int base;
        bit seen;
        bus.rx_data = '0; bus.rx_valid = 1'b0; bus.rx_sof = 1'b0; bus.rx_eof = 1'b0;
        bus.tcam_addr_out = 32'h0A000001;
        bus.tcam_if_idx   = 4'd3;
        bus.route_ready   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; rst4 = 1'b0;
        @(negedge clk);

        chk("rst_route_valid", 32'(bus.route_valid), 32'h0);
        chk("rst_lookup_req",  32'(bus.lookup_req),  32'h0);
        chk("rst_lookup_addr", bus.lookup_addr,      32'h0);
        chk("rst_route_dst",   bus.route_dst,        32'h0);
        chk("rst_stat_ipv4",   32'(bus.stat_ipv4),   32'h0);
        chk("rst_stat_drop",   32'(bus.stat_drop),   32'h0);
        chk("rst_stat_ovf",    32'(bus.stat_ovf),    32'h0);

        // Basic lookup to 192.168.0.1 with exact timing
        build(32'hC0A80001, 16'h0800, 8'h45);
        send_frame(34, 1'b1);
        idle(1);
        chk("t1_req",        32'(bus.lookup_req), 32'h1);
        chk("t1_addr",       bus.lookup_addr,     32'hC0A80001);
        idle(1);
        chk("t1_req_once",   32'(bus.lookup_req),  32'h0);
        chk("t1_rv_early",   32'(bus.route_valid), 32'h0);
        idle(1);
        chk("t1_rv",         32'(bus.route_valid), 32'h1);
        chk("t1_dst",        bus.route_dst,        32'hC0A80001);
        chk("t1_nh",         bus.route_next_hop,   32'h0A000001);
        chk("t1_if",         32'(bus.route_if_idx), 32'h3);
        idle(1);
        chk("t1_rv_clear",   32'(bus.route_valid), 32'h0);
        chk("t1_stat_ipv4",  32'(bus.stat_ipv4),   32'h1);

        // Rejected frames, then parser still works
        base = req_cnt;
        build(32'h01020304, 16'h86DD, 8'h60);
        send_frame(40, 1'b1);
        idle(1);
        build(32'h01020304, 16'h0800, 8'h65);
        send_frame(40, 1'b1);
        idle(3);
        chk("t2_no_req",     32'(req_cnt - base),   32'h0);
        chk("t2_stat_drop",  32'(bus.stat_drop),    32'h2);
        build(32'hAC100509, 16'h0800, 8'h45);
        send_frame(40, 1'b1);
        idle(4);
        chk("t2_req",        32'(req_cnt - base),   32'h1);
        chk("t2_addr",       req_addr,              32'hAC100509);
        chk("t2_stat_ipv4",  32'(bus.stat_ipv4),    32'h2);

        // Truncation: eof at byte 20, sof after byte 24, then a full frame
        base = req_cnt;
        build(32'h11111111, 16'h0800, 8'h45);
        send_frame(21, 1'b1);
        idle(2);
        build(32'h22222222, 16'h0800, 8'h45);
        send_frame(25, 1'b0);
        build(32'h08080404, 16'h0800, 8'h45);
        send_frame(34, 1'b1);
        idle(4);
        chk("t3_stat_drop",  32'(bus.stat_drop),    32'h4);
        chk("t3_one_req",    32'(req_cnt - base),   32'h1);
        chk("t3_addr",       req_addr,              32'h08080404);
        chk("t3_stat_ipv4",  32'(bus.stat_ipv4),    32'h3);

        // Backpressure: second result lost, then same-cycle accept
        bus.route_ready   = 1'b0;
        bus.tcam_addr_out = 32'h0A0000FE;
        bus.tcam_if_idx   = 4'd5;
        build(32'h0A000001, 16'h0800, 8'h45);
        send_frame(34, 1'b1);
        build(32'h0A000002, 16'h0800, 8'h45);
        send_frame(34, 1'b1);
        idle(4);
        chk("t4_rv_held",    32'(bus.route_valid),  32'h1);
        chk("t4_dst_held",   bus.route_dst,         32'h0A000001);
        chk("t4_stat_ovf",   32'(bus.stat_ovf),     32'h1);
        build(32'h0A000002, 16'h0800, 8'h45);
        send_frame(34, 1'b1);
        idle(1);
        chk("t4_req",        32'(bus.lookup_req),   32'h1);
        idle(1);
        chk("t4_dst_before", bus.route_dst,         32'h0A000001);
        bus.route_ready = 1'b1;
        idle(1);
        bus.route_ready = 1'b0;
        chk("t4_rv_stay",    32'(bus.route_valid),  32'h1);
        chk("t4_dst_new",    bus.route_dst,         32'h0A000002);
        chk("t4_nh",         bus.route_next_hop,    32'h0A0000FE);
        chk("t4_ovf_same",   32'(bus.stat_ovf),     32'h1);
        bus.route_ready = 1'b1;
        idle(1);
        chk("t4_rv_clear",   32'(bus.route_valid),  32'h0);

        // Reset during a lookup abandons it
        build(32'h01020304, 16'h0800, 8'h45);
        send_frame(34, 1'b1);
        idle(1);
        chk("t5_req",        32'(bus.lookup_req),   32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.route_valid || bus.lookup_req) seen = 1'b1;
        end
        chk("t5_no_result",  32'(seen),             32'h0);
        chk("t5_stat_ipv4",  32'(bus.stat_ipv4),    32'h0);
        chk("t5_stat_drop",  32'(bus.stat_drop),    32'h0);
        chk("t5_stat_ovf",   32'(bus.stat_ovf),     32'h0);
        chk("t5_lookup_addr", bus.lookup_addr,      32'h0);

        // Saturation of a 4-bit drop counter
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        build(32'h01020304, 16'h0806, 8'h45);
        for (int f = 0; f < 14; f++) begin
            send_frame(34, 1'b1);
            idle(1);
        end
        idle(1);
        chk("t6_drop_14",    32'(bus4.stat_drop),   32'd14);
        for (int f = 0; f < 6; f++) begin
            send_frame(34, 1'b1);
            idle(1);
        end
        idle(1);
        chk("t6_drop_sat",   32'(bus4.stat_drop),   32'd15);
        chk("t6_main_drop",  32'(bus.stat_drop),    32'd20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ipv4_dst_extract.md
# ipv4_dst_extract

Upstream front end for the TCAM route lookup. Parses an 8-bit Ethernet receive byte stream, qualifies IPv4 frames and extracts the destination address. It issues one lookup strobe per qualified frame to the TCAM, captures the TCAM's next-hop and interface result after a fixed latency, and presents it downstream on a valid/ready handshake. It also keeps saturating statistics counters.

## Interface
- `LOOKUP_LAT`, 1: cycles from `lookup_req` to TCAM result valid; legal range 1..15.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: frame byte; byte 0 is the first destination-MAC byte.
- `rx_valid` in 1: `rx_data` is valid this cycle.
- `rx_sof` in 1: first byte of frame; qualified by `rx_valid`.
- `rx_eof` in 1: last byte of frame; qualified by `rx_valid`.
- `lookup_addr` out 32: destination IPv4 address driven to TCAM `addr_in`.
- `lookup_req` out 1: one-cycle lookup strobe, used as the TCAM clock enable.
- `tcam_addr_out` in 32: TCAM next hop.
- `tcam_if_idx` in 4: TCAM interface index.
- `route_valid` out 1: result register holds an unconsumed result.
- `route_ready` in 1: downstream accepts the result.
- `route_dst` out 32: destination address that was looked up.
- `route_next_hop` out 32: captured next hop.
- `route_if_idx` out 4: captured interface index.
- `stat_ipv4` out CNT_W: count of qualified IPv4 frames.
- `stat_drop` out CNT_W: count of rejected or truncated frames.
- `stat_ovf` out CNT_W: count of results lost because the output register was full.

## Operation
- Parser FSM states: IDLE, PARSE, SKIP. A 6-bit byte counter `bc` saturates at 63.
- From any state, `rx_valid && rx_sof` consumes byte 0, sets `bc=1` and enters PARSE. If the state was PARSE when this happens, `stat_drop` increments first because the previous frame was truncated.
- In PARSE, each `rx_valid` byte is checked at its offset `bc`, then `bc` increments:
  - bytes 12,13 must be 0x08,0x00; otherwise `stat_drop`++ and go to SKIP;
  - byte 14 must have upper nibble 4; otherwise `stat_drop`++ and go to SKIP;
  - bytes 30..33 are shifted into the destination register, MSB first;
  - on byte 33: `stat_ipv4`++, load `lookup_addr`, pulse `lookup_req` next cycle, go to SKIP.
- `rx_eof` in PARSE before byte 33: `stat_drop`++, go to IDLE. `rx_eof` on byte 33 itself is valid: the lookup is issued and the state goes to IDLE.
- SKIP: discard bytes until `rx_eof`, then go to IDLE. Bytes in IDLE without `rx_sof` are ignored.
- Lookup tracker: a 4-bit down-counter loads `LOOKUP_LAT` on `lookup_req`. When it expires, `tcam_addr_out` and `tcam_if_idx` are sampled together with the held `lookup_addr`. The minimum frame is 34 bytes and `LOOKUP_LAT` ≤ 15, so two lookups never overlap.
- Output register, single entry, updated on each sampled result:
  - if `route_valid` is 0, or `route_ready` is 1 this cycle: load the result and hold `route_valid` at 1 (no bubble);
  - otherwise: discard the new result and increment `stat_ovf`; the held result is unchanged.
- `route_valid && route_ready` with no new result that cycle clears `route_valid`.
- While `route_valid` is 1, all `route_*` outputs stay stable until accepted.
- Counters saturate at all-ones and never wrap. They are cleared only by `rst`.

## Timing
- Reset values: FSM IDLE, `bc`=0, `lookup_req`=0, `lookup_addr`=0, `route_valid`=0, `route_dst`/`route_next_hop`/`route_if_idx`=0, all stat counters=0, lookup counter idle.
- `rst` mid-frame or mid-lookup abandons all work: no `lookup_req` and no `route_valid` may follow from pre-reset bytes.
- Byte 33 accepted in cycle T → `lookup_addr` valid and `lookup_req`=1 in T+1 (one cycle only).
- TCAM result sampled in T+1+`LOOKUP_LAT` → `route_valid`=1 in T+2+`LOOKUP_LAT`.
- Stat counters update one cycle after the deciding byte.
- Throughput: one byte per cycle; no backpressure on the rx side.

## Test plan
- IPv4 frame to 192.168.0.1, TCAM returning 0x0A000001/if 3, `route_ready`=1, `LOOKUP_LAT`=1 → `lookup_req` one cycle after byte 33 with `lookup_addr`=0xC0A80001; `route_valid` 3 cycles after byte 33 with `route_dst`=0xC0A80001, `route_next_hop`=0x0A000001, `route_if_idx`=3; `stat_ipv4`=1.
- EtherType 0x86DD frame, then an IPv4 frame with version nibble 6 → no `lookup_req`; `stat_drop`=2; the parser still accepts the next valid frame.
- Truncation: `rx_eof` at byte 20, then `rx_sof` at byte 25 of another frame, then a full valid frame → `stat_drop`=2, exactly one lookup, for the final frame.
- Backpressure: `route_ready`=0, two back-to-back valid frames (10.0.0.1, 10.0.0.2) → `route_dst` holds 10.0.0.1, `stat_ovf`=1. A same-cycle accept with a new result loads 10.0.0.2 with `route_valid` staying 1.
- `rst` asserted one cycle after `lookup_req` → no `route_valid`, all counters 0.
- Saturation: `stat_drop` preset near max with `CNT_W`=4, then 20 non-IPv4 frames → `stat_drop` stays at 15.
